// File: rtl/key_event_pkg.sv
// Shared types for the key event front end: per-key debounce state encoding
// and the counter-width helper used by every channel.
package key_event_pkg;

  typedef enum logic [1:0] {
    REL_STABLE = 2'd0,
    PRESS_CHK  = 2'd1,
    PRESSED    = 2'd2,
    REL_CHK    = 2'd3
  } key_state_t;

  // Wide enough to hold the largest sample count without wrapping.
  function automatic int cnt_width(input int db, input int hold, input int rep);
    int m;
    m = db;
    if (hold > m) m = hold;
    if (rep > m) m = rep;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, sample-tick debounce FSM, registered
// press/release pulses and press toggle; auto-repeat only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import key_event_pkg::*;
#(
  parameter int DB_SAMPLES     = 4,
  parameter int HOLD_SAMPLES   = 64,
  parameter int REPEAT_SAMPLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic pb_in,
  output logic pb_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle_state
);
  // state      | meaning
  // REL_STABLE | released and debounced
  // PRESS_CHK  | counting agreeing pressed samples
  // PRESSED    | pressed and debounced
  // REL_CHK    | counting agreeing released samples
  localparam int CW = cnt_width(DB_SAMPLES, HOLD_SAMPLES, REPEAT_SAMPLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_SAMPLES - 1);

  logic          sync_1, sync;
  key_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level_nx, toggle_nx, press_nx, release_nx, rep_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync   <= 1'b0;
    end else begin
      sync_1 <= pb_in;
      sync   <= sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= REL_STABLE;
      cnt           <= '0;
      pb_level      <= 1'b0;
      toggle_state  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pb_level      <= level_nx;
      toggle_state  <= toggle_nx;
      press_pulse   <= press_nx | rep_pulse;
      release_pulse <= release_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    level_nx   = pb_level;
    toggle_nx  = toggle_state;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    if (sample_en) begin
      case (state)
        REL_STABLE: if (sync) begin
          state_nx = PRESS_CHK;
          cnt_nx   = CW'(1);
        end
        PRESS_CHK: if (!sync) begin
          state_nx = REL_STABLE;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx  = PRESSED;
          cnt_nx    = '0;
          level_nx  = 1'b1;
          press_nx  = 1'b1;
          toggle_nx = ~toggle_state;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
        PRESSED: if (!sync) begin
          state_nx = REL_CHK;
          cnt_nx   = CW'(1);
        end
        REL_CHK: if (sync) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx   = REL_STABLE;
          cnt_nx     = '0;
          level_nx   = 1'b0;
          release_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
        default: begin
          state_nx = REL_STABLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_SAMPLES);
  localparam logic [CW-1:0] REP_LD  = CW'(REPEAT_SAMPLES);
  logic [CW-1:0] hold_cnt, hold_nx;

  // Down-counter reloaded on every entry to PRESSED; terminal count fires a repeat.
  always_comb begin
    hold_nx   = '0;
    rep_pulse = 1'b0;
    if (state_nx == PRESSED) begin
      if (state != PRESSED) begin
        hold_nx = HOLD_LD;
      end else if (sample_en && hold_cnt == CW'(1)) begin
        hold_nx   = REP_LD;
        rep_pulse = 1'b1;
      end else if (sample_en) begin
        hold_nx = hold_cnt - 1'b1;
      end else begin
        hold_nx = hold_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold_cnt <= '0;
    else       hold_cnt <= hold_nx;
  end
`else
  assign rep_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_event_unit.sv
// Multi-key button front end: N_KEYS independent debounce channels sharing one
// sample strobe; define KEY_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module key_event_unit
  import key_event_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int DB_SAMPLES     = 4,
  parameter int HOLD_SAMPLES   = 64,
  parameter int REPEAT_SAMPLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [N_KEYS-1:0] pb_in,
  output logic [N_KEYS-1:0] pb_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] toggle_state
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DB_SAMPLES    (DB_SAMPLES),
      .HOLD_SAMPLES  (HOLD_SAMPLES),
      .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .sample_en    (sample_en),
      .pb_in        (pb_in[k]),
      .pb_level     (pb_level[k]),
      .press_pulse  (press_pulse[k]),
      .release_pulse(release_pulse[k]),
      .toggle_state (toggle_state[k])
    );
  end

endmodule
